alu_issue_stage: RTL and testbench
==================================

Name: alu_issue_stage

Overview:
- Producer side of the 3-bit ALU-control/operand interface. Decodes a MIPS instruction word into the ALU opcode, selects and extends operands, and registers the result into a 2-entry elastic ID/EX buffer.
- The EX stage consumes the buffer head through a valid/ready handshake. The buffer head drives the ALU's opcode/rs/rt inputs directly.
- Sits between register-file read (ID) and the ALU (EX) in the pipelined CPU.

Parameters:
- DEPTH, 2, buffer entries. The block is specified and verified only at 2.
- W, 32, datapath width.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  ID offers an instruction
- in_ready  out  1  buffer can accept; equals count<DEPTH, from registered count only
- instr  in  32  instruction word
- rs_data  in  W  register-file value of instr[25:21]
- rt_data  in  W  register-file value of instr[20:16]
- flush  in  1  discard all buffered entries (branch/exception)
- out_valid  out  1  head entry valid
- out_ready  in  1  EX consumes head
- alu_opcode  out  3  head ALU control
- alu_rs  out  W  head operand A
- alu_rt  out  W  head operand B
- wb_addr  out  5  head destination register; 0 means no writeback
- illegal  out  1  head instruction was undecodable

Behaviour:
- ALU encodings (shared): AND=000, OR=001, ADD=010, SUB=110, SLT=111, NOP=011. NOP makes the ALU output 0.
- R-type (instr[31:26]=0x00), decoded on funct:
  - 0x20 and 0x21 → ADD
  - 0x22 and 0x23 → SUB
  - 0x24 → AND
  - 0x25 → OR
  - 0x2A → SLT
  - For all of the above: B=rt_data, wb=instr[15:11].
- I-type, decoded on opcode:
  - 0x08 addi → ADD, B=sign-extended imm16, wb=rt
  - 0x0A slti → SLT, B=sign-extended imm16, wb=rt
  - 0x0C andi → AND, B=zero-extended imm16, wb=rt
  - 0x0D ori → OR, B=zero-extended imm16, wb=rt
  - 0x23 lw → ADD, B=sign-extended imm16, wb=rt
  - 0x2B sw → ADD, B=sign-extended imm16, wb=0
  - 0x04 beq → SUB, B=rt_data, wb=0
- Operand A is always rs_data.
- Any other opcode, or any other R-type funct → NOP, illegal=1, wb=0, A=B=0. Illegal entries still occupy the buffer and still handshake.
- Accept on in_valid&&in_ready. Pop on out_valid&&out_ready.
- Decode is combinational on the input side. Entries store decoded fields only.
- Latency: an entry accepted at edge N into an empty buffer is visible at the head after edge N. Sustained throughput is 1 per cycle.
- Storage: circular buffer, 1-bit wrapping read/write pointers, 2-bit count 0..2.
  - in_ready=(count!=2).
  - out_valid=(count!=0).
- Count update per cycle:
  - push only → +1
  - pop only → -1
  - push and pop in the same cycle → unchanged, both pointers advance
- Full (count=2): in_ready=0. A same-cycle pop does not enable a push (no combinational ready path).
- Empty (count=0): out_valid=0. Head outputs show the stale entry; consumers must ignore them.
- Flush has priority over push and pop in the same cycle. Next state: count=0, both pointers 0. The input offered in the flush cycle is dropped.
- Reset (asynchronous, any time including mid-transfer): count=0, pointers=0, out_valid=0, in_ready=1, and every stored field cleared. Head outputs after reset: alu_opcode=011, alu_rs=0, alu_rt=0, wb_addr=0, illegal=0.
- Head outputs come straight from the storage mux. No combinational path from in_* to out_*.

Decomposition:
- Package alu_pkg:
  - ALU opcode constants
  - MIPS opcode and funct constants
  - packed entry struct {opcode, a, b, wb, illegal}
- Sub-module alu_ctrl_decode: purely combinational instr/rs_data/rt_data → entry struct. The top level holds the buffer and handshake.

Test Plan:
- After reset, instr=0x00851020 (add $2,$4,$5), rs=3, rt=4, out_ready=1 → next cycle out_valid=1, opcode=010, A=3, B=4, wb=2. Driving an ALU instance gives out=7.
- addi $3,$1,-1 (0x2023FFFF), rs=5 → B=0xFFFFFFFF, ALU out=4. ori $3,$1,0xFFFF → B=0x0000FFFF.
- out_ready=0 with 3 back-to-back valid inputs → 2 accepted, in_ready=0 on the 3rd. Release out_ready → pops in order, no loss or duplication.
- count=1 with push and pop in the same cycle, held for 10 cycles → count stays 1, outputs match input order.
- count=2, then flush and in_valid in the same cycle → next cycle out_valid=0, in_ready=1, dropped input never appears.
- instr=0xFC000000 → illegal=1, opcode=011, wb=0, ALU out=0. Assert rst_n=0 asynchronously mid-stream → out_valid falls immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU control encodings, MIPS opcode/funct values and the ID/EX entry
// type used by the issue stage and its decoder.
package alu_pkg;

   localparam int DATA_W = 32;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_NOP = 3'b011;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_ADD  = 6'h20;
   localparam logic [5:0] FN_ADDU = 6'h21;
   localparam logic [5:0] FN_SUB  = 6'h22;
   localparam logic [5:0] FN_SUBU = 6'h23;
   localparam logic [5:0] FN_AND  = 6'h24;
   localparam logic [5:0] FN_OR   = 6'h25;
   localparam logic [5:0] FN_SLT  = 6'h2A;

   typedef struct packed {
      logic [2:0]        opcode;
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
      logic [4:0]        wb;
      logic              illegal;
   } entry_t;

   localparam entry_t RESET_ENTRY = '{opcode: ALU_NOP, a: 32'd0, b: 32'd0, wb: 5'd0, illegal: 1'b0};
   localparam entry_t ILLEGAL_ENTRY = '{opcode: ALU_NOP, a: 32'd0, b: 32'd0, wb: 5'd0, illegal: 1'b1};

   function automatic entry_t make_entry(input logic [2:0] op, input logic [DATA_W-1:0] a,
                                         input logic [DATA_W-1:0] b, input logic [4:0] wb);
      entry_t e;
      e.opcode  = op;
      e.a       = a;
      e.b       = b;
      e.wb      = wb;
      e.illegal = 1'b0;
      return e;
   endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational decode of a MIPS instruction word plus register operands into
// one ID/EX entry (ALU control, operands A/B, writeback register, illegal flag).
module alu_ctrl_decode
   import alu_pkg::*;
(
   input  logic [31:0]       i_instr,
   input  logic [DATA_W-1:0] i_rs_data,
   input  logic [DATA_W-1:0] i_rt_data,
   output entry_t            o_entry
);

   logic [5:0]        w_op;
   logic [5:0]        w_funct;
   logic [4:0]        w_rt;
   logic [4:0]        w_rd;
   logic [DATA_W-1:0] w_sext;
   logic [DATA_W-1:0] w_zext;
   logic [2:0]        w_rop;
   logic              w_rlegal;

   assign w_op    = i_instr[31:26];
   assign w_funct = i_instr[5:0];
   assign w_rt    = i_instr[20:16];
   assign w_rd    = i_instr[15:11];
   assign w_sext  = {{16{i_instr[15]}}, i_instr[15:0]};
   assign w_zext  = {16'd0, i_instr[15:0]};

   // R-type funct to ALU control
   always_comb begin
      w_rop    = ALU_NOP;
      w_rlegal = 1'b1;
      case (w_funct)
         FN_ADD, FN_ADDU: w_rop = ALU_ADD;
         FN_SUB, FN_SUBU: w_rop = ALU_SUB;
         FN_AND:          w_rop = ALU_AND;
         FN_OR:           w_rop = ALU_OR;
         FN_SLT:          w_rop = ALU_SLT;
         default:         w_rlegal = 1'b0;
      endcase
   end

   // Opcode decode; anything unrecognised becomes an all-zero illegal NOP
   always_comb begin
      o_entry = ILLEGAL_ENTRY;
      case (w_op)
         OP_RTYPE: begin
            if (w_rlegal) begin
               o_entry = make_entry(w_rop, i_rs_data, i_rt_data, w_rd);
            end else begin
               o_entry = ILLEGAL_ENTRY;
            end
         end
         OP_ADDI: o_entry = make_entry(ALU_ADD, i_rs_data, w_sext, w_rt);
         OP_SLTI: o_entry = make_entry(ALU_SLT, i_rs_data, w_sext, w_rt);
         OP_ANDI: o_entry = make_entry(ALU_AND, i_rs_data, w_zext, w_rt);
         OP_ORI:  o_entry = make_entry(ALU_OR,  i_rs_data, w_zext, w_rt);
         OP_LW:   o_entry = make_entry(ALU_ADD, i_rs_data, w_sext, w_rt);
         OP_SW:   o_entry = make_entry(ALU_ADD, i_rs_data, w_sext, 5'd0);
         OP_BEQ:  o_entry = make_entry(ALU_SUB, i_rs_data, i_rt_data, 5'd0);
         default: o_entry = ILLEGAL_ENTRY;
      endcase
   end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX issue stage: decodes the offered instruction and holds decoded entries
// in a 2-deep elastic buffer whose head feeds the ALU through valid/ready.
module alu_issue_stage
   import alu_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int W     = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [31:0]  instr,
   input  logic [W-1:0] rs_data,
   input  logic [W-1:0] rt_data,
   input  logic         flush,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [2:0]   alu_opcode,
   output logic [W-1:0] alu_rs,
   output logic [W-1:0] alu_rt,
   output logic [4:0]   wb_addr,
   output logic         illegal
);

   localparam logic [1:0] FULL_CNT = 2'(DEPTH);

   entry_t     r_mem [DEPTH];
   logic       r_wr_ptr;
   logic       r_rd_ptr;
   logic [1:0] r_count;

   entry_t     w_dec;
   entry_t     w_head;
   logic       w_push;
   logic       w_pop;

   alu_ctrl_decode u_decode (
      .i_instr   (instr),
      .i_rs_data (rs_data),
      .i_rt_data (rt_data),
      .o_entry   (w_dec)
   );

   // Ready/valid depend only on the registered count, never on the peer's signal
   assign in_ready = (r_count != FULL_CNT);
   assign out_valid = (r_count != 2'd0);
   assign w_push = in_valid && in_ready;
   assign w_pop  = out_valid && out_ready;

   assign w_head     = r_mem[r_rd_ptr];
   assign alu_opcode = w_head.opcode;
   assign alu_rs     = w_head.a;
   assign alu_rt     = w_head.b;
   assign wb_addr    = w_head.wb;
   assign illegal    = w_head.illegal;

   // Circular buffer storage, pointers and occupancy; flush beats push/pop
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= RESET_ENTRY;
         end
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else if (flush) begin
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= w_dec;
            r_wr_ptr        <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Randomised self-checking bench for alu_issue_stage against a mnemonic-level
// decode model and a queue model of the ID/EX buffer.
module tb_alu_issue_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] instr;
   logic [31:0] rs_data;
   logic [31:0] rt_data;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [2:0]  alu_opcode;
   logic [31:0] alu_rs;
   logic [31:0] alu_rt;
   logic [4:0]  wb_addr;
   logic        illegal;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  wb;
      logic        ill;
   } exp_t;

   exp_t q[$];

   alu_issue_stage dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .instr      (instr),
      .rs_data    (rs_data),
      .rt_data    (rt_data),
      .flush      (flush),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .alu_opcode (alu_opcode),
      .alu_rs     (alu_rs),
      .alu_rt     (alu_rt),
      .wb_addr    (wb_addr),
      .illegal    (illegal)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic string mnem(input logic [31:0] i);
      case (i[31:26])
         6'h00: begin
            case (i[5:0])
               6'h20, 6'h21: return "add";
               6'h22, 6'h23: return "sub";
               6'h24:        return "and";
               6'h25:        return "or";
               6'h2A:        return "slt";
               default:      return "ill";
            endcase
         end
         6'h08:   return "addi";
         6'h0A:   return "slti";
         6'h0C:   return "andi";
         6'h0D:   return "ori";
         6'h23:   return "lw";
         6'h2B:   return "sw";
         6'h04:   return "beq";
         default: return "ill";
      endcase
   endfunction

   function automatic exp_t ref_decode(input logic [31:0] i, input logic [31:0] rs, input logic [31:0] rt);
      exp_t e;
      logic [31:0] sx;
      logic [31:0] zx;
      string m;
      sx = 32'($signed(i[15:0]));
      zx = 32'(i[15:0]);
      m = mnem(i);
      e = '{op: 3'b011, a: 32'd0, b: 32'd0, wb: 5'd0, ill: 1'b1};
      case (m)
         "add":  e = '{3'b010, rs, rt, i[15:11], 1'b0};
         "sub":  e = '{3'b110, rs, rt, i[15:11], 1'b0};
         "and":  e = '{3'b000, rs, rt, i[15:11], 1'b0};
         "or":   e = '{3'b001, rs, rt, i[15:11], 1'b0};
         "slt":  e = '{3'b111, rs, rt, i[15:11], 1'b0};
         "addi": e = '{3'b010, rs, sx, i[20:16], 1'b0};
         "slti": e = '{3'b111, rs, sx, i[20:16], 1'b0};
         "andi": e = '{3'b000, rs, zx, i[20:16], 1'b0};
         "ori":  e = '{3'b001, rs, zx, i[20:16], 1'b0};
         "lw":   e = '{3'b010, rs, sx, i[20:16], 1'b0};
         "sw":   e = '{3'b010, rs, sx, 5'd0, 1'b0};
         "beq":  e = '{3'b110, rs, rt, 5'd0, 1'b0};
         default: e = '{3'b011, 32'd0, 32'd0, 5'd0, 1'b1};
      endcase
      return e;
   endfunction

   function automatic logic [31:0] alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      case (op)
         3'b000:  return a & b;
         3'b001:  return a | b;
         3'b010:  return a + b;
         3'b110:  return a - b;
         3'b111:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         default: return 32'd0;
      endcase
   endfunction

   task automatic check_outputs(input string tag);
      check_val({tag, ".out_valid"}, 64'(out_valid), 64'(q.size() != 0));
      check_val({tag, ".in_ready"},  64'(in_ready),  64'(q.size() < 2));
      if (q.size() != 0) begin
         check_val({tag, ".opcode"},  64'(alu_opcode), 64'(q[0].op));
         check_val({tag, ".alu_rs"},  64'(alu_rs),     64'(q[0].a));
         check_val({tag, ".alu_rt"},  64'(alu_rt),     64'(q[0].b));
         check_val({tag, ".wb_addr"}, 64'(wb_addr),    64'(q[0].wb));
         check_val({tag, ".illegal"}, 64'(illegal),    64'(q[0].ill));
      end
   endtask

   // Inputs are already driven; advance one clock, update the model, check at negedge
   task automatic step(input string tag);
      bit   m_push;
      bit   m_pop;
      exp_t e;
      m_push = in_valid && (q.size() < 2);
      m_pop  = out_ready && (q.size() != 0);
      e = ref_decode(instr, rs_data, rt_data);
      @(posedge clk);
      if (flush) begin
         q.delete();
      end else begin
         if (m_pop)  void'(q.pop_front());
         if (m_push) q.push_back(e);
      end
      @(negedge clk);
      check_outputs(tag);
   endtask

   task automatic drive(input bit v, input logic [31:0] i, input logic [31:0] rs,
                        input logic [31:0] rt, input bit rdy, input bit fl);
      in_valid = v; instr = i; rs_data = rs; rt_data = rt; out_ready = rdy; flush = fl;
   endtask

   function automatic logic [31:0] rand_instr();
      logic [31:0] i;
      logic [5:0]  ops [8] = '{6'h00, 6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h23, 6'h2B, 6'h04};
      logic [5:0]  fns [7] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h2A};
      i = $urandom;
      if ($urandom_range(0, 7) != 0) i[31:26] = ops[$urandom_range(0, 7)];
      if (i[31:26] == 6'h00 && $urandom_range(0, 5) != 0) i[5:0] = fns[$urandom_range(0, 6)];
      return i;
   endfunction

   initial begin
      drive(1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      check_outputs("reset");
      check_val("reset.opcode",  64'(alu_opcode), 64'(3'b011));
      check_val("reset.alu_rs",  64'(alu_rs),     64'd0);
      check_val("reset.alu_rt",  64'(alu_rt),     64'd0);
      check_val("reset.wb_addr", 64'(wb_addr),    64'd0);
      check_val("reset.illegal", 64'(illegal),    64'd0);

      // add $2,$4,$5 with rs=3, rt=4
      drive(1'b1, 32'h00851020, 32'd3, 32'd4, 1'b1, 1'b0);
      step("add");
      check_val("add.valid", 64'(out_valid), 64'd1);
      check_val("add.wb", 64'(wb_addr), 64'd2);
      check_val("add.aluout", 64'(alu(alu_opcode, alu_rs, alu_rt)), 64'd7);

      drive(1'b1, 32'h2023FFFF, 32'd5, 32'd99, 1'b1, 1'b0);
      step("addi");
      check_val("addi.b", 64'(alu_rt), 64'hFFFFFFFF);
      check_val("addi.aluout", 64'(alu(alu_opcode, alu_rs, alu_rt)), 64'd4);

      drive(1'b1, 32'h3423FFFF, 32'd5, 32'd99, 1'b1, 1'b0);
      step("ori");
      check_val("ori.b", 64'(alu_rt), 64'h0000FFFF);

      // Backpressure: three offers, two accepted
      drive(1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
      step("drain");
      for (int k = 0; k < 3; k++) begin
         drive(1'b1, rand_instr(), $urandom, $urandom, 1'b0, 1'b0);
         step("bp.fill");
      end
      check_val("bp.full_ready", 64'(in_ready), 64'd0);
      for (int k = 0; k < 3; k++) begin
         drive(1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
         step("bp.drain");
      end

      // Steady push+pop at count=1
      drive(1'b1, 32'h00851020, 32'd1, 32'd2, 1'b0, 1'b0);
      step("ss.prime");
      for (int k = 0; k < 10; k++) begin
         drive(1'b1, rand_instr(), $urandom, $urandom, 1'b1, 1'b0);
         step("ss");
         check_val("ss.count1", 64'(out_valid && in_ready), 64'd1);
      end

      // Fill, then flush with a concurrent offer
      drive(1'b1, rand_instr(), $urandom, $urandom, 1'b0, 1'b0);
      step("fl.fill");
      drive(1'b1, 32'h00851020, 32'h1234, 32'h5678, 1'b1, 1'b1);
      step("flush");
      check_val("flush.out_valid", 64'(out_valid), 64'd0);
      check_val("flush.in_ready", 64'(in_ready), 64'd1);
      drive(1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
      step("flush.after");

      // Illegal instruction
      drive(1'b1, 32'hFC000000, 32'd77, 32'd88, 1'b0, 1'b0);
      step("ill");
      check_val("ill.flag", 64'(illegal), 64'd1);
      check_val("ill.opcode", 64'(alu_opcode), 64'(3'b011));
      check_val("ill.aluout", 64'(alu(alu_opcode, alu_rs, alu_rt)), 64'd0);

      // Asynchronous reset between clock edges
      drive(1'b1, rand_instr(), $urandom, $urandom, 1'b0, 1'b0);
      step("ar.fill");
      #2;
      rst_n = 1'b0;
      #1;
      q.delete();
      check_val("areset.out_valid", 64'(out_valid), 64'd0);
      check_val("areset.in_ready", 64'(in_ready), 64'd1);
      check_val("areset.opcode", 64'(alu_opcode), 64'(3'b011));
      check_val("areset.wb_addr", 64'(wb_addr), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Random traffic
      for (int k = 0; k < 400; k++) begin
         drive(1'($urandom_range(0, 3) != 0), rand_instr(), $urandom, $urandom,
               1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0));
         step("rand");
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
